// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor: pulses the PLL reset, qualifies lock, then
// releases the per-domain resets one at a time and pulls them all back on lock loss.
module pll_reset_sequencer #(
    parameter int NUM_DOMAINS         = 4,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGE_GAP_CYCLES    = 16,
    parameter int RELOCK_CNT_W        = 8
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic                    sw_reset_req,
    output logic                    pll_rst,
    output logic [NUM_DOMAINS-1:0]  domain_rst_n,
    output logic                    all_ready,
    output logic                    lock_lost,
    output logic [RELOCK_CNT_W-1:0] relock_count,
    output logic [RELOCK_CNT_W-1:0] timeout_count,
    output logic [2:0]              state
);

    localparam logic [2:0] ST_PLL_RESET = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLES = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                     max2(LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES));
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);

    localparam logic [RELOCK_CNT_W-1:0] CNT_ONE = RELOCK_CNT_W'(1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_d;
    logic                   lock_s;
    logic                   req_s;
    logic                   req_rise;
    logic [CNT_W-1:0]       cnt;

    // Both inputs come from other clock domains, so each passes a plain flop chain.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
            req_sync  <= '0;
            req_d     <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
            req_sync  <= {req_sync[SYNC_STAGES-2:0], sw_reset_req};
            req_d     <= req_s;
        end
    end

    assign lock_s   = lock_sync[SYNC_STAGES-1];
    assign req_s    = req_sync[SYNC_STAGES-1];
    assign req_rise = req_s & ~req_d;

    // One shared cycle counter serves every timed state; it restarts on each transition.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_PLL_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            domain_rst_n  <= '0;
            all_ready     <= 1'b0;
            lock_lost     <= 1'b0;
            relock_count  <= '0;
            timeout_count <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (req_rise) begin
                state        <= ST_PLL_RESET;
                cnt          <= '0;
                pll_rst      <= 1'b1;
                domain_rst_n <= '0;
                all_ready    <= 1'b0;
            end else begin
                case (state)
                    ST_PLL_RESET: begin
                        if (cnt == PLL_RST_LAST) begin
                            state   <= ST_WAIT_LOCK;
                            cnt     <= '0;
                            pll_rst <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == TIMEOUT_LAST) begin
                            state   <= ST_PLL_RESET;
                            cnt     <= '0;
                            pll_rst <= 1'b1;
                            if (timeout_count != '1)
                                timeout_count <= timeout_count + CNT_ONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!lock_s) begin
                            state <= ST_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state        <= ST_RELEASE;
                            cnt          <= '0;
                            domain_rst_n <= NUM_DOMAINS'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE, ST_RUN: begin
                        if (!lock_s) begin
                            state        <= ST_WAIT_LOCK;
                            cnt          <= '0;
                            domain_rst_n <= '0;
                            all_ready    <= 1'b0;
                            lock_lost    <= 1'b1;
                            if (relock_count != '1)
                                relock_count <= relock_count + CNT_ONE;
                        end else if (state == ST_RELEASE) begin
                            // Released bits form a contiguous run from bit 0; the top bit marks completion.
                            if (domain_rst_n[NUM_DOMAINS-1]) begin
                                state     <= ST_RUN;
                                all_ready <= 1'b1;
                            end else if (cnt == GAP_LAST) begin
                                cnt          <= '0;
                                domain_rst_n <= (domain_rst_n << 1) | NUM_DOMAINS'(1);
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state        <= ST_PLL_RESET;
                        cnt          <= '0;
                        pll_rst      <= 1'b1;
                        domain_rst_n <= '0;
                        all_ready    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing scenarios plus random lock/request
// traffic, all checked every cycle against an elapsed-time model of the sequencer.
module tb_pll_reset_sequencer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int PRC  = 4;
    localparam int LSC  = 8;
    localparam int TO   = 32;
    localparam int GAP  = 4;
    localparam int CW   = 8;

    localparam int P_RESET   = 0;
    localparam int P_WAIT    = 1;
    localparam int P_STABLE  = 2;
    localparam int P_RELEASE = 3;
    localparam int P_RUN     = 4;

    logic          refclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_locked = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic          pll_rst;
    logic [N-1:0]  domain_rst_n;
    logic          all_ready;
    logic          lock_lost;
    logic [CW-1:0] relock_count;
    logic [CW-1:0] timeout_count;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;
    int lost_seen = 0;
    int rst_seen = 0;
    int rise_at [N+1];
    int exp_rise [N+1] = '{11, 15, 19, 23, 24};

    // Model: phase plus cycles spent in it; outputs are derived from those two numbers.
    int m_phase = P_RESET;
    int m_elapsed = 0;
    int m_relocks = 0;
    int m_timeouts = 0;
    int m_next = P_RESET;
    bit m_lost = 1'b0;
    bit m_lock_now = 1'b0;
    bit m_req_edge = 1'b0;
    bit lh [SYNC+1];
    bit rh [SYNC+1];

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .NUM_DOMAINS(N), .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC),
        .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(TO),
        .STAGE_GAP_CYCLES(GAP), .RELOCK_CNT_W(CW)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req), .pll_rst(pll_rst),
        .domain_rst_n(domain_rst_n), .all_ready(all_ready),
        .lock_lost(lock_lost), .relock_count(relock_count),
        .timeout_count(timeout_count), .state(state)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lock, input logic req, input int hold);
        @(negedge refclk);
        pll_locked   = lock;
        sw_reset_req = req;
        repeat (hold - 1) @(negedge refclk);
    endtask

    function automatic logic [N-1:0] model_domains();
        int k;
        if (m_phase == P_RUN) return '1;
        if (m_phase != P_RELEASE) return '0;
        k = m_elapsed / GAP + 1;
        if (k > N) k = N;
        return N'((1 << k) - 1);
    endfunction

    function automatic int sat_inc(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_RESET;
            m_elapsed = 0;
            m_relocks = 0;
            m_timeouts = 0;
            m_lost = 1'b0;
            for (int i = 0; i <= SYNC; i++) begin
                lh[i] = 1'b0;
                rh[i] = 1'b0;
            end
        end else begin
            m_lock_now = lh[SYNC-1];
            m_req_edge = rh[SYNC-1] && !rh[SYNC];
            for (int i = SYNC; i > 0; i--) begin
                lh[i] = lh[i-1];
                rh[i] = rh[i-1];
            end
            lh[0] = pll_locked;
            rh[0] = sw_reset_req;
            m_lost = 1'b0;
            m_next = m_phase;
            if (m_req_edge) begin
                m_next = P_RESET;
            end else if (m_phase == P_RESET) begin
                if (m_elapsed + 1 == PRC) m_next = P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if (m_lock_now) m_next = P_STABLE;
                else if (m_elapsed + 1 == TO) begin
                    m_next = P_RESET;
                    m_timeouts = sat_inc(m_timeouts);
                end
            end else if (m_phase == P_STABLE) begin
                if (!m_lock_now) m_next = P_WAIT;
                else if (m_elapsed + 1 == LSC) m_next = P_RELEASE;
            end else begin
                if (!m_lock_now) begin
                    m_next = P_WAIT;
                    m_lost = 1'b1;
                    m_relocks = sat_inc(m_relocks);
                end else if (m_phase == P_RELEASE && m_elapsed == (N - 1) * GAP) begin
                    m_next = P_RUN;
                end
            end
            if (m_req_edge || m_next != m_phase) m_elapsed = 0;
            else m_elapsed++;
            m_phase = m_next;
        end
    end

    // Every cycle the whole output set is compared against the model.
    always begin
        @(posedge refclk);
        #1;
        checkOutput("pll_rst", {31'd0, pll_rst}, {31'd0, m_phase == P_RESET});
        checkOutput("domain_rst_n", {28'd0, domain_rst_n}, {28'd0, model_domains()});
        checkOutput("all_ready", {31'd0, all_ready}, {31'd0, m_phase == P_RUN});
        checkOutput("lock_lost", {31'd0, lock_lost}, {31'd0, m_lost});
        checkOutput("relock_count", {24'd0, relock_count}, m_relocks);
        checkOutput("timeout_count", {24'd0, timeout_count}, m_timeouts);
        checkOutput("state", {29'd0, state}, m_phase);
        if (lock_lost === 1'b1) lost_seen++;
        if (pll_rst === 1'b1) rst_seen++;
    end

    task automatic measure_release(input string tag);
        for (int i = 0; i <= N; i++) rise_at[i] = -1;
        @(negedge refclk);
        pll_locked = 1'b1;
        for (int e = 1; e <= 80 && rise_at[N] < 0; e++) begin
            @(posedge refclk);
            #1;
            for (int i = 0; i < N; i++)
                if (domain_rst_n[i] === 1'b1 && rise_at[i] < 0) rise_at[i] = e;
            if (all_ready === 1'b1 && rise_at[N] < 0) rise_at[N] = e;
        end
        for (int i = 0; i <= N; i++)
            checkOutput($sformatf("%s_rise%0d", tag, i), rise_at[i], exp_rise[i]);
    endtask

    task automatic wait_domains_clear(input string tag, input int expect_edges);
        int e;
        e = 0;
        while (domain_rst_n !== '0 && e < 20) begin
            @(posedge refclk);
            #1;
            e++;
        end
        checkOutput(tag, e, expect_edges);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e;
        int stalls;
        int rises [3];
        int nr;
        logic prev;

        repeat (3) @(negedge refclk);
        checkOutput("reset_pll_rst", {31'd0, pll_rst}, 1);
        checkOutput("reset_domains", {28'd0, domain_rst_n}, 0);
        checkOutput("reset_state", {29'd0, state}, 0);

        $display("[TB] power-up sequence");
        @(negedge refclk);
        rst_n = 1'b1;
        e = 0;
        do begin
            @(posedge refclk);
            #1;
            e++;
        end while (pll_rst === 1'b1 && e < 20);
        checkOutput("powerup_pll_rst_edges", e, 4);
        measure_release("powerup");

        $display("[TB] request together with lock loss in RUN");
        rst_seen = 0;
        lost_seen = 0;
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("req_pll_rst_cycles", rst_seen, 4);
        checkOutput("req_no_lock_lost", lost_seen, 0);
        checkOutput("req_relock_count", {24'd0, relock_count}, 0);

        $display("[TB] lock chatter during qualification");
        lost_seen = 0;
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b0, 1'b0, 3);
        measure_release("chatter");
        checkOutput("chatter_no_lock_lost", lost_seen, 0);
        checkOutput("chatter_relock_count", {24'd0, relock_count}, 0);

        $display("[TB] lock loss in RUN and relock");
        lost_seen = 0;
        @(negedge refclk);
        pll_locked = 1'b0;
        wait_domains_clear("run_loss_edges", 3);
        repeat (6) @(negedge refclk);
        checkOutput("run_loss_pulses", lost_seen, 1);
        checkOutput("run_loss_relock_count", {24'd0, relock_count}, 1);
        rst_seen = 0;
        measure_release("relock");
        checkOutput("relock_no_pll_rst", rst_seen, 0);

        $display("[TB] lock loss mid-release");
        applyStimulus(1'b0, 1'b0, 6);
        @(negedge refclk);
        pll_locked = 1'b1;
        e = 0;
        while (domain_rst_n[1] !== 1'b1 && e < 40) begin
            @(posedge refclk);
            #1;
            e++;
        end
        checkOutput("mid_release_dom1_edges", e, 15);
        @(negedge refclk);
        pll_locked = 1'b0;
        wait_domains_clear("mid_release_loss_edges", 3);
        checkOutput("mid_release_relock_count", {24'd0, relock_count}, 3);

        $display("[TB] lock timeout");
        nr = 0;
        prev = pll_rst;
        for (int k = 1; k <= 150 && nr < 3; k++) begin
            @(posedge refclk);
            #1;
            if (pll_rst === 1'b1 && prev !== 1'b1) begin
                rises[nr] = k;
                nr++;
            end
            prev = pll_rst;
        end
        checkOutput("timeout_rise_count", nr, 3);
        checkOutput("timeout_first_rise", rises[0], 32);
        checkOutput("timeout_period_a", rises[1] - rises[0], 36);
        checkOutput("timeout_period_b", rises[2] - rises[1], 36);
        checkOutput("timeout_count_value", {24'd0, timeout_count}, 3);

        $display("[TB] asynchronous reset mid-run");
        @(negedge refclk);
        pll_locked = 1'b1;
        e = 0;
        while (all_ready !== 1'b1 && e < 80) begin
            @(posedge refclk);
            #1;
            e++;
        end
        checkOutput("async_reached_run", {31'd0, all_ready}, 1);
        @(negedge refclk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_pll_rst", {31'd0, pll_rst}, 1);
        checkOutput("async_domains", {28'd0, domain_rst_n}, 0);
        checkOutput("async_all_ready", {31'd0, all_ready}, 0);
        checkOutput("async_timeout_count", {24'd0, timeout_count}, 0);
        checkOutput("async_relock_count", {24'd0, relock_count}, 0);
        @(negedge refclk);
        rst_n = 1'b1;

        $display("[TB] random traffic");
        for (int it = 0; it < 90; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                @(negedge refclk);
                rst_n = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge refclk);
                rst_n = 1'b1;
            end else if (r < 14) begin
                applyStimulus(pll_locked, 1'b1, $urandom_range(1, 3));
                applyStimulus(pll_locked, 1'b0, 1);
            end else if (r < 75) begin
                applyStimulus(1'b1, 1'b0, $urandom_range(1, 50));
            end else begin
                applyStimulus(1'b0, 1'b0, $urandom_range(1, 40));
            end
        end

        $display("[TB] relock counter saturation");
        @(negedge refclk);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        sw_reset_req = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;
        stalls = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge refclk);
            pll_locked = 1'b1;
            e = 0;
            while (domain_rst_n[0] !== 1'b1 && e < 40) begin
                @(negedge refclk);
                e++;
            end
            if (e >= 40) stalls++;
            pll_locked = 1'b0;
            e = 0;
            while (domain_rst_n[0] !== 1'b0 && e < 10) begin
                @(negedge refclk);
                e++;
            end
            if (e >= 10) stalls++;
        end
        checkOutput("saturation_stalls", stalls, 0);
        checkOutput("saturation_relock_count", {24'd0, relock_count}, 255);

        repeat (2) @(negedge refclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
